// File: rtl/vga_pkg.sv
// Shared VGA definitions: memory-port control, colour type, fill-engine states
// and the pixel address helper used by the fill and blit blocks.
package vga_pkg;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic [3:0] byteEn;
    } mem_ctrl_t;

    typedef logic [31:0] vga_color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } vga_fill_state_t;

    localparam logic [31:0] VGA_PXL_BASE  = 32'h1002_0000;
    localparam logic [31:0] VGA_SWAP_ADDR = 32'h1003_0000;

    // Byte offset of pixel (x,y) inside the pixel window: row-major with a
    // 256-pixel pitch, one 32-bit word per pixel.
    function automatic logic [31:0] vga_pxl_addr(input logic [7:0] x, input logic [7:0] y);
        return {14'd0, y, x, 2'b00};
    endfunction

endpackage

// File: rtl/vga_rect_clip.sv
// Combinational rectangle clipper: clamps the rectangle's far edges to the
// frame and flags rectangles that cover no visible pixel.
module vga_rect_clip #(
    parameter int FRAME_W = 160,
    parameter int FRAME_H = 120
) (
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [8:0] w_i,
    input  logic [8:0] h_i,
    output logic [9:0] xe_o,
    output logic [9:0] ye_o,
    output logic       empty_o
);

    logic [9:0] x_end;
    logic [9:0] y_end;

    // Far edges in 10 bits so x0+w never wraps, then clamp to the frame.
    always_comb begin
        x_end   = {2'b00, x0_i} + {1'b0, w_i};
        y_end   = {2'b00, y0_i} + {1'b0, h_i};
        xe_o    = (x_end > 10'(FRAME_W)) ? 10'(FRAME_W) : x_end;
        ye_o    = (y_end > 10'(FRAME_H)) ? 10'(FRAME_H) : y_end;
        empty_o = ({2'b00, x0_i} >= 10'(FRAME_W)) || ({2'b00, y0_i} >= 10'(FRAME_H))
                  || (w_i == 9'd0) || (h_i == 9'd0);
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: writes one clipped pixel per unstalled cycle onto the
// VGA memory write port, optionally followed by the buffer-swap write.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int          FRAME_W   = 160,
    parameter int          FRAME_H   = 120,
    parameter logic [31:0] PXL_BASE  = VGA_PXL_BASE,
    parameter logic [31:0] SWAP_ADDR = VGA_SWAP_ADDR
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [7:0]  i_x0,
    input  logic [7:0]  i_y0,
    input  logic [8:0]  i_w,
    input  logic [8:0]  i_h,
    input  logic [31:0] i_color,
    input  logic        i_swap,
    input  logic        i_stall,
    output logic [31:0] o_pxlAddr,
    output logic [31:0] o_pxlData,
    output mem_ctrl_t   o_ctrlVGA,
    output logic        o_busy,
    output logic        o_done
);

    vga_fill_state_t state_q;
    logic [7:0]      x_q, y_q, x0_q;
    logic [9:0]      xe_q, ye_q;
    vga_color_t      color_q;
    logic            swap_q;
    logic [31:0]     addr_q, data_q;
    mem_ctrl_t       ctrl_q;
    logic            busy_q, done_q;

    logic [9:0]      xe_d, ye_d;
    logic            empty_d;
    logic            x_last, y_last;

    vga_rect_clip #(
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H)
    ) u_clip (
        .x0_i   (i_x0),
        .y0_i   (i_y0),
        .w_i    (i_w),
        .h_i    (i_h),
        .xe_o   (xe_d),
        .ye_o   (ye_d),
        .empty_o(empty_d)
    );

    // End-of-row / end-of-rectangle detection on the current pixel.
    always_comb begin
        x_last = (({2'b00, x_q} + 10'd1) == xe_q);
        y_last = (({2'b00, y_q} + 10'd1) == ye_q);
    end

    // Fill FSM with X/Y raster counters; port outputs are registered and
    // default to zero every cycle so only real writes show memWrite.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            swap_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q <= '0;
            data_q <= '0;
            ctrl_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        x_q     <= i_x0;
                        y_q     <= i_y0;
                        x0_q    <= i_x0;
                        xe_q    <= xe_d;
                        ye_q    <= ye_d;
                        color_q <= i_color;
                        swap_q  <= i_swap;
                        busy_q  <= 1'b1;
                        if (empty_d) begin
                            state_q <= i_swap ? SWAP : DONE;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (!i_stall) begin
                        ctrl_q.memWrite <= 1'b1;
                        addr_q          <= PXL_BASE + vga_pxl_addr(x_q, y_q);
                        data_q          <= color_q;
                        if (x_last) begin
                            x_q <= x0_q;
                            if (y_last) begin
                                state_q <= swap_q ? SWAP : DONE;
                            end else begin
                                y_q <= y_q + 8'd1;
                            end
                        end else begin
                            x_q <= x_q + 8'd1;
                        end
                    end
                end
                SWAP: begin
                    if (!i_stall) begin
                        ctrl_q.memWrite <= 1'b1;
                        addr_q          <= SWAP_ADDR;
                        data_q          <= '0;
                        state_q         <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_pxlAddr = addr_q;
    assign o_pxlData = data_q;
    assign o_ctrlVGA = ctrl_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: logs every write and completion pulse with
// its cycle number, then checks each command against hand-computed values.
module tb_vga_rect_fill;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x0 = '0, y0 = '0;
    logic [8:0]  w = '0, h = '0;
    logic [31:0] color = '0;
    logic        swap = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pxl_addr, pxl_data;
    mem_ctrl_t   ctrl;
    logic        busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int s = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int bad_ctrl = 0;
    logic busy_at_done = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    vga_rect_fill dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .i_start  (start),
        .i_x0     (x0),
        .i_y0     (y0),
        .i_w      (w),
        .i_h      (h),
        .i_color  (color),
        .i_swap   (swap),
        .i_stall  (stall),
        .o_pxlAddr(pxl_addr),
        .o_pxlData(pxl_data),
        .o_ctrlVGA(ctrl),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one log line per write transaction and per completion pulse.
    always @(negedge clk) begin
        if (ctrl.memRead || ctrl.byteEn != 4'd0) bad_ctrl++;
        if (ctrl.memWrite) begin
            wa.push_back(pxl_addr);
            wd.push_back(pxl_data);
            wc.push_back(cyc);
            $display("[TB] cyc %0d write addr=%h data=%h", cyc, pxl_addr, pxl_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
            $display("[TB] cyc %0d done", cyc);
        end
    end

    function automatic logic [31:0] exp_addr(input int x, input int y);
        return 32'h1002_0000 + 32'((y * 256 + x) * 4);
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command; returns at the cycle after the start cycle (s+1).
    task automatic start_cmd(input int ax, input int ay, input int aw, input int ah,
                             input logic [31:0] acol, input logic asw);
        wa.delete(); wd.delete(); wc.delete();
        done_cnt = 0;
        x0 = 8'(ax); y0 = 8'(ay); w = 9'(aw); h = 9'(ah);
        color = acol; swap = asw; start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        x0 = 8'($urandom); y0 = 8'($urandom); w = 9'($urandom); h = 9'($urandom);
        color = $urandom; swap = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_addr", pxl_addr, 32'd0);
        check("rst_data", pxl_data, 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic 2x2 fill
        start_cmd(3, 5, 2, 2, 32'h2A, 1'b0);
        check("basic_busy_early", 32'(busy), 32'd1);
        wait_done("basic", 20);
        check("basic_nwr", wa.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_addr%0d", i), (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF,
                  exp_addr(3 + i % 2, 5 + i / 2));
            check($sformatf("basic_data%0d", i), (i < wd.size()) ? wd[i] : 32'hFFFF_FFFF, 32'h2A);
        end
        check("basic_first_cyc", (wc.size() > 0) ? 32'(wc[0]) : 32'hFFFF_FFFF, 32'(s + 2));
        check("basic_done_cyc", 32'(done_cyc), 32'(s + 6));
        check("basic_busy_at_done", 32'(busy_at_done), 32'd0);
        tick();
        check("basic_busy_after", 32'(busy), 32'd0);

        // Clip at the bottom-right corner
        start_cmd(158, 119, 5, 4, 32'h0000_00C1, 1'b0);
        wait_done("clip", 20);
        check("clip_nwr", wa.size(), 32'd2);
        check("clip_addr0", (wa.size() > 0) ? wa[0] : 32'hFFFF_FFFF, exp_addr(158, 119));
        check("clip_addr1", (wa.size() > 1) ? wa[1] : 32'hFFFF_FFFF, exp_addr(159, 119));

        // Stall for two cycles after the first write of a 4-pixel row
        start_cmd(10, 20, 4, 1, 32'h5555_AAAA, 1'b0);
        tick();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        wait_done("stall", 20);
        check("stall_nwr", wa.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_addr%0d", i), (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF,
                  exp_addr(10 + i, 20));
        end
        check("stall_wr1_cyc", (wc.size() > 1) ? 32'(wc[1]) : 32'hFFFF_FFFF, 32'(s + 5));
        check("stall_done_cyc", 32'(done_cyc), 32'(s + 8));

        // 1x1 fill followed by swap
        start_cmd(7, 9, 1, 1, 32'hDEAD_BEEF, 1'b1);
        wait_done("swap", 20);
        check("swap_nwr", wa.size(), 32'd2);
        check("swap_pxl_addr", (wa.size() > 0) ? wa[0] : 32'hFFFF_FFFF, exp_addr(7, 9));
        check("swap_pxl_data", (wd.size() > 0) ? wd[0] : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        check("swap_addr", (wa.size() > 1) ? wa[1] : 32'hFFFF_FFFF, 32'h1003_0000);
        check("swap_data", (wd.size() > 1) ? wd[1] : 32'hFFFF_FFFF, 32'd0);
        check("swap_done_cyc", 32'(done_cyc), 32'(s + 4));

        // Empty (off-frame) rectangle with swap: the swap write only
        start_cmd(200, 0, 5, 5, 32'h1234_5678, 1'b1);
        wait_done("eswap", 20);
        check("eswap_nwr", wa.size(), 32'd1);
        check("eswap_addr", (wa.size() > 0) ? wa[0] : 32'hFFFF_FFFF, 32'h1003_0000);
        check("eswap_cyc", (wc.size() > 0) ? 32'(wc[0]) : 32'hFFFF_FFFF, 32'(s + 2));
        check("eswap_done_cyc", 32'(done_cyc), 32'(s + 3));

        // Zero width, no swap
        start_cmd(4, 4, 0, 3, 32'hFFFF_FFFF, 1'b0);
        wait_done("zero", 20);
        check("zero_nwr", wa.size(), 32'd0);
        check("zero_done_cyc", 32'(done_cyc), 32'(s + 2));

        // Start pulsed mid-fill is ignored
        start_cmd(0, 0, 3, 1, 32'h11, 1'b0);
        tick();
        tick();
        x0 = 8'd50; y0 = 8'd50; w = 9'd1; h = 9'd1; color = 32'h99; swap = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("reiss", 20);
        repeat (6) tick();
        check("reiss_nwr", wa.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reiss_addr%0d", i), (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF,
                  exp_addr(i, 0));
        end
        check("reiss_done_cyc", 32'(done_cyc), 32'(s + 5));
        check("reiss_done_cnt", 32'(done_cnt), 32'd1);

        // Reset after three writes of a 10-pixel fill
        start_cmd(0, 1, 10, 1, 32'hCAFE_F00D, 1'b1);
        tick();
        tick();
        tick();
        check("rmid_nwr_before", wa.size(), 32'd3);
        reset_n = 1'b0;
        tick();
        check("rmid_addr", pxl_addr, 32'd0);
        check("rmid_data", pxl_data, 32'd0);
        check("rmid_ctrl", 32'(ctrl), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (15) tick();
        check("rmid_nwr_after", wa.size(), 32'd3);
        check("rmid_no_done", 32'(done_cnt), 32'd0);

        // Fresh command after the abort
        start_cmd(1, 1, 1, 1, 32'h7, 1'b0);
        wait_done("post", 20);
        check("post_nwr", wa.size(), 32'd1);
        check("post_addr", (wa.size() > 0) ? wa[0] : 32'hFFFF_FFFF, exp_addr(1, 1));
        check("post_done_cyc", 32'(done_cyc), 32'(s + 3));

        check("ctrl_other_fields", 32'(bad_ctrl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
